// File: rtl/accel_xyz_packetizer.sv
// accel_xyz_packetizer: collects a 6-byte ADXL345 XYZ burst and streams it as a checksummed 8-byte UART frame
module accel_xyz_packetizer #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              burst_start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_byte,
  output logic [15:0]       x_data,
  output logic [15:0]       y_data,
  output logic [15:0]       z_data,
  output logic              sample_strobe,
  output logic              frame_busy,
  output logic [DROP_W-1:0] drop_count
);
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_HDR  = 4'd1;
  localparam logic [3:0] S_CSUM = 4'd8;
  logic [3:0]  r_state;
  logic [2:0]  r_idx;
  logic [47:0] r_cap, r_frm;
  logic [2:0]  w_idx, w_bi;
  logic        w_wr, w_done, w_hs, w_free, w_accept;
  logic [47:0] w_new, w_frm, w_sh;
  logic [3:0]  w_nstate;
  logic [7:0]  w_csum, w_ntx;
  assign w_idx    = burst_start ? 3'd0 : r_idx;
  assign w_wr     = rx_valid && w_idx != 3'd6;
  assign w_done   = w_wr && w_idx == 3'd5;
  assign w_hs     = tx_valid && tx_ready;
  // The CSUM handshake frees the buffer in the same cycle, so back-to-back frames have no gap.
  assign w_free   = r_state == S_IDLE || (r_state == S_CSUM && w_hs);
  assign w_accept = w_done && w_free;
  assign w_new    = {rx_byte, r_cap[39:0]};
  assign w_frm    = w_accept ? w_new : r_frm;
  assign w_nstate = w_accept ? S_HDR : !w_hs ? r_state : r_state == S_CSUM ? S_IDLE : r_state + 4'd1;
  assign w_csum   = w_frm[7:0] ^ w_frm[15:8] ^ w_frm[23:16] ^ w_frm[31:24] ^ w_frm[39:32] ^ w_frm[47:40];
  assign w_bi     = w_nstate[2:0] - 3'd2;
  assign w_sh     = w_frm >> {w_bi, 3'b000};
  assign w_ntx    = w_nstate == S_IDLE ? 8'd0 : w_nstate == S_HDR ? HEADER : w_nstate == S_CSUM ? w_csum : w_sh[7:0];
  assign frame_busy = tx_valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= 3'd0;
      r_cap         <= '0;
      r_frm         <= '0;
      tx_valid      <= 1'b0;
      tx_byte       <= 8'd0;
      x_data        <= 16'd0;
      y_data        <= 16'd0;
      z_data        <= 16'd0;
      sample_strobe <= 1'b0;
      drop_count    <= '0;
    end else begin
      r_state       <= w_nstate;
      r_frm         <= w_frm;
      tx_valid      <= w_nstate != S_IDLE;
      tx_byte       <= w_ntx;
      sample_strobe <= w_accept;
      if (burst_start || w_wr) r_idx <= w_idx + {2'b00, w_wr};
      if (w_wr) r_cap[{w_idx, 3'b000} +: 8] <= rx_byte;
      if (w_accept) {z_data, y_data, x_data} <= w_new;
      if (w_done && !w_free && drop_count != '1) drop_count <= drop_count + DROP_W'(1);
    end
  end
endmodule

// File: tb/tb_accel_xyz_packetizer.sv
// tb_accel_xyz_packetizer: directed scenarios plus random traffic checked against a frame-queue reference model
module tb_accel_xyz_packetizer;
  logic        clk = 1'b0;
  logic        reset = 1'b1, burst_start = 1'b0, rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic        tx_valid, sample_strobe, frame_busy;
  logic [7:0]  tx_byte, drop_count;
  logic [15:0] x_data, y_data, z_data;
  accel_xyz_packetizer dut (
    .clk(clk), .reset(reset), .burst_start(burst_start), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_byte(tx_byte), .x_data(x_data), .y_data(y_data),
    .z_data(z_data), .sample_strobe(sample_strobe), .frame_busy(frame_busy), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0, cyc = 0, tr_mode = 1;
  int         m_idx = 0, m_drop = 0;
  logic [7:0] m_cap [6];
  logic [7:0] q [$];
  logic [15:0] mx = 0, my = 0, mz = 0;
  logic       m_strobe = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask
  function automatic logic trv();
    return tr_mode == 1 ? 1'b1 : tr_mode == 0 ? 1'b0 : tr_mode == 2 ? cyc[0] : 1'($urandom_range(0, 1));
  endfunction
  task automatic step(input logic rs, input logic bs, input logic rv, input logic [7:0] rb, input logic tr);
    logic hs, free, done;
    logic [7:0] cs;
    reset = rs; burst_start = bs; rx_valid = rv; rx_byte = rb; tx_ready = tr;
    if (rs) begin
      m_idx = 0; q.delete(); mx = 0; my = 0; mz = 0; m_strobe = 0; m_drop = 0;
    end else begin
      hs   = q.size() > 0 && tr;
      free = q.size() == 0 || (q.size() == 1 && hs);
      done = 0;
      if (bs) m_idx = 0;
      if (rv && m_idx < 6) begin
        m_cap[m_idx] = rb;
        m_idx++;
        done = m_idx == 6;
      end
      if (hs) void'(q.pop_front());
      m_strobe = 0;
      if (done) begin
        if (free) begin
          cs = 0;
          q.push_back(8'hA5);
          for (int i = 0; i < 6; i++) begin q.push_back(m_cap[i]); cs ^= m_cap[i]; end
          q.push_back(cs);
          mx = {m_cap[1], m_cap[0]}; my = {m_cap[3], m_cap[2]}; mz = {m_cap[5], m_cap[4]};
          m_strobe = 1;
        end else if (m_drop < 255) m_drop++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("tx_valid", tx_valid, q.size() > 0);
    chk("frame_busy", frame_busy, q.size() > 0);
    if (q.size() > 0) chk("tx_byte", tx_byte, q[0]);
    else if (rs) chk("tx_byte_rst", tx_byte, 0);
    chk("x_data", x_data, mx);
    chk("y_data", y_data, my);
    chk("z_data", z_data, mz);
    chk("sample_strobe", sample_strobe, m_strobe);
    chk("drop_count", drop_count, m_drop);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'd0, trv());
  endtask
  task automatic burst(input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) step(0, i == 0, 1, d[8*i +: 8], trv());
  endtask
  initial begin
    step(1, 0, 0, 8'd0, 0);
    step(1, 0, 0, 8'd0, 0);
    tr_mode = 1; burst(64'h0001_ABCD_1234, 6); idle(10);
    tr_mode = 2; burst(64'h0001_ABCD_1234, 6); idle(20);
    tr_mode = 0; burst(64'h6655_4433_2211, 6); burst(64'hCCBB_AA99_8877, 6); idle(3);
    tr_mode = 1; idle(10);
    burst(64'hEEFF_0102_0304_0506, 8); burst(64'h1F2E_3D4C_5B6A, 6); idle(12);
    burst(64'h0F0E_0D0C_0B0A, 6); idle(2); burst(64'hF0E0_D0C0_B0A0, 6); idle(12);
    burst(64'h7788_99AA_BBCC, 6); idle(4);
    step(1, 0, 1, 8'h55, 1);
    idle(2); burst(64'h0123_4567_89AB, 6); idle(12);
    tr_mode = 0;
    for (int k = 0; k < 258; k++) burst({$urandom(), $urandom()}, 6);
    chk("drop_saturated", drop_count, 8'hFF);
    tr_mode = 1; idle(10);
    step(1, 0, 0, 8'd0, 1);
    tr_mode = 3;
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), 8'($urandom()), trv());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
